// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads the icache, and registers
// fetched instructions (with pc_plus_4) into the fetch/decode pipeline
// register. A one-entry skid buffer catches an icache hit that arrives
// while decode is stalled.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc_plus_4,
    output logic        out_valid
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [XLEN-1:0]   pc_n;
    logic [XLEN-1:0]   instr_n, ppc4_n;
    logic              valid_n;
    logic [XLEN-1:0]   skid_instr, skid_instr_n;
    logic [XLEN-1:0]   skid_ppc4, skid_ppc4_n;
    logic [XLEN-1:0]   pc_plus_4_c;

    // Sequential address of the current fetch (modulo 2^32)
    assign pc_plus_4_c = pc + XLEN'(4);

    // The icache address always tracks the fetch PC
    assign imemaddr = pc;

    // State, PC, fetch/decode register and skid buffer
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state         <= FETCH;
            pc            <= PC_INIT;
            out_instr     <= '0;
            out_pc_plus_4 <= '0;
            out_valid     <= 1'b0;
            skid_instr    <= '0;
            skid_ppc4     <= '0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            out_instr     <= instr_n;
            out_pc_plus_4 <= ppc4_n;
            out_valid     <= valid_n;
            skid_instr    <= skid_instr_n;
            skid_ppc4     <= skid_ppc4_n;
        end
    end

    // Next-state and next-register logic; priority halt > redirect > stall > advance
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        instr_n      = out_instr;
        ppc4_n       = out_pc_plus_4;
        valid_n      = out_valid;
        skid_instr_n = skid_instr;
        skid_ppc4_n  = skid_ppc4;
        imemREN      = 1'b0;

        case (state)
            FETCH: begin
                imemREN = 1'b1;
                if (halt) begin
                    instr_n = '0;
                    ppc4_n  = '0;
                    valid_n = 1'b0;
                    state_n = HALTED;
                end else if (redirect) begin
                    pc_n         = redirect_pc;
                    instr_n      = '0;
                    ppc4_n       = '0;
                    valid_n      = 1'b0;
                    skid_instr_n = '0;
                    skid_ppc4_n  = '0;
                end else if (stall) begin
                    // Decode is busy: park a hit in the skid buffer, keep outputs
                    if (ihit) begin
                        skid_instr_n = imemload;
                        skid_ppc4_n  = pc_plus_4_c;
                        pc_n         = pc_plus_4_c;
                        state_n      = HOLD;
                    end
                end else if (ihit) begin
                    instr_n = imemload;
                    ppc4_n  = pc_plus_4_c;
                    valid_n = 1'b1;
                    pc_n    = pc_plus_4_c;
                end else begin
                    instr_n = '0;
                    ppc4_n  = '0;
                    valid_n = 1'b0;
                end
            end
            HOLD: begin
                if (halt) begin
                    instr_n = '0;
                    ppc4_n  = '0;
                    valid_n = 1'b0;
                    state_n = HALTED;
                end else if (redirect) begin
                    pc_n         = redirect_pc;
                    instr_n      = '0;
                    ppc4_n       = '0;
                    valid_n      = 1'b0;
                    skid_instr_n = '0;
                    skid_ppc4_n  = '0;
                    state_n      = FETCH;
                end else if (!stall) begin
                    // Drain the buffered instruction; PC already points past it
                    instr_n      = skid_instr;
                    ppc4_n       = skid_ppc4;
                    valid_n      = 1'b1;
                    skid_instr_n = '0;
                    skid_ppc4_n  = '0;
                    state_n      = FETCH;
                end
            end
            HALTED: begin
                instr_n = '0;
                ppc4_n  = '0;
                valid_n = 1'b0;
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table for the main pipeline
// flow plus hand-written sequences for asynchronous reset and PC wrap.
module tb_fetch_stage;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] out_instr;
    logic [31:0] out_pc_plus_4;
    logic        out_valid;

    int errors = 0;
    int checks = 0;

    fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
        .CLK(CLK),
        .nRST(nRST),
        .imemREN(imemREN),
        .imemaddr(imemaddr),
        .ihit(ihit),
        .imemload(imemload),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .halt(halt),
        .pc(pc),
        .out_instr(out_instr),
        .out_pc_plus_4(out_pc_plus_4),
        .out_valid(out_valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        ihit;
        logic        stall;
        logic        redirect;
        logic        halt;
        logic [31:0] load;
        logic [31:0] rpc;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pp4;
        logic        e_valid;
        logic        e_ren;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_pp4, input logic e_valid, input logic e_ren);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".imemaddr"}, imemaddr, e_pc);
        chk({tag, ".out_instr"}, out_instr, e_instr);
        chk({tag, ".out_pc_plus_4"}, out_pc_plus_4, e_pp4);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
        chk({tag, ".imemREN"}, 32'(imemREN), 32'(e_ren));
    endtask

    task automatic drive(input logic h, input logic s, input logic r, input logic hl,
                         input logic [31:0] ld, input logic [31:0] rp);
        ihit = h; stall = s; redirect = r; halt = hl; imemload = ld; redirect_pc = rp;
    endtask

    initial begin
        //          ihit stall redir halt load           rpc            pc             instr          pp4            v     ren
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h2001_0005, 32'h0,        32'h0000_0004, 32'h2001_0005, 32'h0000_0004, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h2002_0003, 32'h0,        32'h0000_0008, 32'h2002_0003, 32'h0000_0008, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0,        32'h0000_0008, 32'h0,         32'h0,         1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0,        32'h0000_0008, 32'h0,         32'h0,         1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0,        32'h0000_0008, 32'h0,         32'h0,         1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h2003_0001, 32'h0,        32'h0000_000C, 32'h2003_0001, 32'h0000_000C, 1'b1, 1'b1};
        // stall coincident with hit at pc 12 -> HOLD, outputs frozen
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h2004_0002, 32'h0,        32'h0000_0010, 32'h2003_0001, 32'h0000_000C, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hBAD0_0001, 32'h0,        32'h0000_0010, 32'h2003_0001, 32'h0000_000C, 1'b1, 1'b0};
        // release: buffered word at 12 issues, fetch resumes at 16
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hBAD0_0002, 32'h0,        32'h0000_0010, 32'h2004_0002, 32'h0000_0010, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h2005_0004, 32'h0,        32'h0000_0014, 32'h2005_0004, 32'h0000_0014, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h2006_0006, 32'h0,        32'h0000_0018, 32'h2005_0004, 32'h0000_0014, 1'b1, 1'b0};
        // redirect during HOLD with stall still high
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'hBAD0_0003, 32'h0000_0040, 32'h0000_0040, 32'h0,        32'h0,         1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h2007_0040, 32'h0,        32'h0000_0044, 32'h2007_0040, 32'h0000_0044, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h2008_0044, 32'h0,        32'h0000_0048, 32'h2008_0044, 32'h0000_0048, 1'b1, 1'b1};
        // stall without hit in FETCH: everything holds
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hBAD0_0004, 32'h0,        32'h0000_0048, 32'h2008_0044, 32'h0000_0048, 1'b1, 1'b1};
        // halt beats redirect and hit
        vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hBAD0_0005, 32'h0000_0000, 32'h0000_0048, 32'h0,        32'h0,         1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hBAD0_0006, 32'h0000_0000, 32'h0000_0048, 32'h0,        32'h0,         1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hBAD0_0007, 32'h0,        32'h0000_0048, 32'h0,         32'h0,         1'b0, 1'b0};

        nRST = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #12;
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        nRST = 1'b1;
        @(posedge CLK); #1;

        // Table-driven main flow: inputs held through one edge, outputs checked 1 after it
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].ihit, vecs[i].stall, vecs[i].redirect, vecs[i].halt, vecs[i].load, vecs[i].rpc);
            @(posedge CLK); #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pp4,
                    vecs[i].e_valid, vecs[i].e_ren);
        end

        // Asynchronous reset from HALTED, then enter HOLD and reset mid-stall
        nRST = 1'b0;
        #1;
        chk_all("rst_halted", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        nRST = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h1111_0000, 32'h0);
        @(posedge CLK); #1;
        chk_all("post_rst_fetch", 32'h4, 32'h1111_0000, 32'h4, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h2222_0004, 32'h0);
        @(posedge CLK); #1;
        chk_all("hold_again", 32'h8, 32'h1111_0000, 32'h4, 1'b1, 1'b0);
        #2;
        nRST = 1'b0;
        #1;
        chk_all("rst_mid_hold", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        #1;
        nRST = 1'b1;
        // Buffered word must be lost: no hit, no stall -> bubble
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge CLK); #1;
        chk_all("skid_lost", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

        // PC wrap: redirect to the top word, then hit
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC);
        @(posedge CLK); #1;
        chk_all("redir_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h3333_FFFC, 32'h0);
        @(posedge CLK); #1;
        chk_all("wrap", 32'h0, 32'h3333_FFFC, 32'h0, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
